// File: rtl/param_combination_lock.sv
// Parametrised combination lock: digit entry, retry counter with timed lockout, confirmed password change.
// Latency: the final digit's ent edge enters CHECK/CONF_CHECK; the next edge enters the result state and pulses ok/err.
// Backpressure: none; ent/clr/change are single-cycle pulses, and the states that cannot use them ignore them.
module param_combination_lock #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGIT_W-1:0]        sw,
    input  logic                      ent,
    input  logic                      clr,
    input  logic                      change,
    output logic [2:0]                mode,
    output logic [3:0]                digit_idx,
    output logic [DIGITS*DIGIT_W-1:0] entry,
    output logic [3:0]                fails,
    output logic                      unlocked,
    output logic                      lockout,
    output logic                      ok,
    output logic                      err
);

    localparam int CW = DIGITS * DIGIT_W;

    localparam logic [2:0] S_LOCKED     = 3'd0;
    localparam logic [2:0] S_ENTER      = 3'd1;
    localparam logic [2:0] S_CHECK      = 3'd2;
    localparam logic [2:0] S_OPEN       = 3'd3;
    localparam logic [2:0] S_NEW        = 3'd4;
    localparam logic [2:0] S_CONFIRM    = 3'd5;
    localparam logic [2:0] S_CONF_CHECK = 3'd6;
    localparam logic [2:0] S_LOCKOUT    = 3'd7;

    localparam logic [3:0]  LAST_IDX  = 4'(DIGITS - 1);
    localparam logic [3:0]  TRY_LIMIT = 4'(MAX_TRIES);
    localparam logic [23:0] LOCK_LOAD = 24'(LOCKOUT_CYCLES - 1);

    logic [2:0]    state_q,   state_n;
    logic [3:0]    idx_q,     idx_n;
    logic [CW-1:0] entry_q,   entry_n;
    logic [CW-1:0] shadow_q,  shadow_n;
    logic [CW-1:0] pw_q,      pw_n;
    logic [3:0]    fails_q,   fails_n;
    logic [23:0]   timer_q,   timer_n;
    logic          ok_q,      ok_n;
    logic          err_q,     err_n;
    logic          unlock_q,  unlock_n;
    logic          lockout_q, lockout_n;

    logic [CW-1:0] entry_cap;
    logic [CW-1:0] shadow_cap;
    logic          last;
    logic [3:0]    fails_inc;

    assign last      = (idx_q == LAST_IDX);
    assign fails_inc = fails_q + 4'd1;

    // Place sw into the digit slot selected by idx_q (digit 0 sits in the MSBs).
    always_comb begin
        entry_cap  = entry_q;
        shadow_cap = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (4'(i) == idx_q) begin
                entry_cap[(DIGITS-1-i)*DIGIT_W +: DIGIT_W]  = sw;
                shadow_cap[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
            end
        end
    end

    // Next-state and datapath update for every mode.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        entry_n  = entry_q;
        shadow_n = shadow_q;
        pw_n     = pw_q;
        fails_n  = fails_q;
        timer_n  = timer_q;
        ok_n     = 1'b0;
        err_n    = 1'b0;

        case (state_q)
            S_LOCKED: begin
                if (ent) begin
                    entry_n = entry_cap;
                    if (last) begin
                        state_n = S_CHECK;
                    end else begin
                        idx_n   = idx_q + 4'd1;
                        state_n = S_ENTER;
                    end
                end
            end
            S_ENTER: begin
                if (clr) begin
                    state_n = S_LOCKED;
                    entry_n = '0;
                    idx_n   = 4'd0;
                end else if (ent) begin
                    entry_n = entry_cap;
                    if (last) state_n = S_CHECK;
                    else      idx_n   = idx_q + 4'd1;
                end
            end
            S_CHECK: begin
                entry_n = '0;
                idx_n   = 4'd0;
                if (entry_q == pw_q) begin
                    state_n = S_OPEN;
                    fails_n = 4'd0;
                    ok_n    = 1'b1;
                end else begin
                    err_n   = 1'b1;
                    fails_n = fails_inc;
                    if (fails_inc >= TRY_LIMIT) begin
                        state_n = S_LOCKOUT;
                        timer_n = LOCK_LOAD;
                    end else begin
                        state_n = S_LOCKED;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_q == 24'd0) begin
                    state_n = S_LOCKED;
                    fails_n = 4'd0;
                end else begin
                    timer_n = timer_q - 24'd1;
                end
            end
            S_OPEN: begin
                // change takes precedence over a relock request in the same cycle
                if (change) begin
                    state_n = S_NEW;
                    entry_n = '0;
                    idx_n   = 4'd0;
                end else if (ent) begin
                    state_n = S_LOCKED;
                end
            end
            S_NEW: begin
                if (clr) begin
                    state_n  = S_OPEN;
                    shadow_n = '0;
                    entry_n  = '0;
                    idx_n    = 4'd0;
                end else if (ent) begin
                    shadow_n = shadow_cap;
                    if (last) begin
                        state_n = S_CONFIRM;
                        entry_n = '0;
                        idx_n   = 4'd0;
                    end else begin
                        idx_n = idx_q + 4'd1;
                    end
                end
            end
            S_CONFIRM: begin
                if (clr) begin
                    state_n  = S_OPEN;
                    shadow_n = '0;
                    entry_n  = '0;
                    idx_n    = 4'd0;
                end else if (ent) begin
                    entry_n = entry_cap;
                    if (last) state_n = S_CONF_CHECK;
                    else      idx_n   = idx_q + 4'd1;
                end
            end
            S_CONF_CHECK: begin
                if (entry_q == shadow_q) begin
                    pw_n = shadow_q;
                    ok_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
                state_n  = S_OPEN;
                entry_n  = '0;
                shadow_n = '0;
                idx_n    = 4'd0;
            end
            default: begin
                state_n = S_LOCKED;
                entry_n = '0;
                idx_n   = 4'd0;
            end
        endcase
    end

    // Status flags are derived from the next state so they register alongside mode.
    always_comb begin
        unlock_n  = (state_n == S_OPEN) || (state_n == S_NEW) ||
                    (state_n == S_CONFIRM) || (state_n == S_CONF_CHECK);
        lockout_n = (state_n == S_LOCKOUT);
    end

    // State registers; reset also restores the factory password.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LOCKED;
            idx_q     <= 4'd0;
            entry_q   <= '0;
            shadow_q  <= '0;
            pw_q      <= RESET_CODE;
            fails_q   <= 4'd0;
            timer_q   <= 24'd0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            entry_q   <= entry_n;
            shadow_q  <= shadow_n;
            pw_q      <= pw_n;
            fails_q   <= fails_n;
            timer_q   <= timer_n;
            ok_q      <= ok_n;
            err_q     <= err_n;
            unlock_q  <= unlock_n;
            lockout_q <= lockout_n;
        end
    end

    assign mode      = state_q;
    assign digit_idx = idx_q;
    assign entry     = entry_q;
    assign fails     = fails_q;
    assign unlocked  = unlock_q;
    assign lockout   = lockout_q;
    assign ok        = ok_q;
    assign err       = err_q;

endmodule
